// File: rtl/regfile_wr_arbiter_if.sv
// Write-port arbitration bundle: requester handshakes, registered register-file
// write port, hazard-check ports and status.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_REQ    = 3,
  parameter int READ_PORTS = 2,
  parameter int GIDX_W     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data;
  logic                              rf_wren;
  logic [ADDR_W-1:0]                 rf_wraddr;
  logic [DATA_W-1:0]                 rf_data_in;
  logic [READ_PORTS-1:0][ADDR_W-1:0] chk_addr;
  logic [READ_PORTS-1:0]             chk_busy;
  logic [GIDX_W-1:0]                 grant_idx;
  logic                              idle;

  modport master (
    output req_valid, req_addr, req_data, chk_addr,
    input  req_ready, rf_wren, rf_wraddr, rf_data_in, chk_busy, grant_idx, idle
  );

  modport slave (
    input  req_valid, req_addr, req_data, chk_addr,
    output req_ready, rf_wren, rf_wraddr, rf_data_in, chk_busy, grant_idx, idle
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port; one registered stage,
// so acceptance-to-commit is 1 cycle; no back-pressure, one write accepted per cycle.
module regfile_wr_arbiter #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int NUM_REQ    = 3,
  parameter int READ_PORTS = 2,
  parameter bit ZERO_REG   = 1'b1
) (
  input logic             clk,
  input logic             rstn,
  regfile_wr_arbiter_if.slave bus
);
  localparam int GIDX_W = $clog2(NUM_REQ);

  logic [GIDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              stage_valid_q, stage_valid_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [GIDX_W-1:0] grant_q, grant_d;

  logic [NUM_REQ-1:0] ready_c;
  logic [GIDX_W-1:0]  win;
  logic               found;
  logic [GIDX_W-1:0]  idx;

  // First valid requester at or after rr_ptr wins.
  always_comb begin
    ready_c = '0;
    win     = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = GIDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found && rstn) begin
      ready_c[win] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    stage_valid_d = 1'b0;
    wraddr_d      = wraddr_q;
    wdata_d       = wdata_q;
    grant_d       = grant_q;
    if (found) begin
      rr_ptr_d      = (win == GIDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      stage_valid_d = 1'b1;
      wraddr_d      = bus.req_addr[win];
      wdata_d       = bus.req_data[win];
      grant_d       = win;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q      <= '0;
      stage_valid_q <= 1'b0;
      wraddr_q      <= '0;
      wdata_q       <= '0;
      grant_q       <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      stage_valid_q <= stage_valid_d;
      wraddr_q      <= wraddr_d;
      wdata_q       <= wdata_d;
      grant_q       <= grant_d;
    end
  end

  // Busy covers both the waiting requests and the write sitting in the stage.
  always_comb begin
    bus.chk_busy = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (stage_valid_q && (wraddr_q == bus.chk_addr[p])) begin
        bus.chk_busy[p] = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && (bus.req_addr[i] == bus.chk_addr[p])) begin
          bus.chk_busy[p] = 1'b1;
        end
      end
      if (ZERO_REG && (bus.chk_addr[p] == '0)) begin
        bus.chk_busy[p] = 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.rf_wren    = stage_valid_q && !(ZERO_REG && (wraddr_q == '0));
  assign bus.rf_wraddr  = wraddr_q;
  assign bus.rf_data_in = wdata_q;
  assign bus.grant_idx  = grant_q;
  assign bus.idle       = ~|bus.req_valid && !stage_valid_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with hand-computed expectations.
module tb_regfile_wr_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREQ   = 3;
  localparam int NRP    = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REQ(NREQ),
                          .READ_PORTS(NRP)) bus ();

  regfile_wr_arbiter #(.DATA_W(DATA_W), .NUM_REGS(32), .ADDR_W(ADDR_W),
                       .NUM_REQ(NREQ), .READ_PORTS(NRP), .ZERO_REG(1'b1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.chk_addr  = '0;

    // Reset state; ready held low during reset even with requests present.
    #3;
    chk("rst_wren", 32'(bus.rf_wren), 32'd0);
    chk("rst_wraddr", 32'(bus.rf_wraddr), 32'd0);
    chk("rst_data", bus.rf_data_in, 32'd0);
    chk("rst_grant", 32'(bus.grant_idx), 32'd0);
    bus.req_valid = 3'b111;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_idle_busyreq", 32'(bus.idle), 32'd0);
    bus.req_valid = '0;
    #1;
    chk("rst_idle", 32'(bus.idle), 32'd1);
    #8 rstn = 1'b1;
    tick();

    // Single request on req 1.
    bus.req_valid   = 3'b010;
    bus.req_addr[1] = 5'd5;
    bus.req_data[1] = 32'hA5A5_A5A5;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    #1;
    chk("single_wren", 32'(bus.rf_wren), 32'd1);
    chk("single_addr", 32'(bus.rf_wraddr), 32'd5);
    chk("single_data", bus.rf_data_in, 32'hA5A5_A5A5);
    chk("single_grant", 32'(bus.grant_idx), 32'd1);
    tick();
    chk("single_wren_off", 32'(bus.rf_wren), 32'd0);
    chk("single_idle", 32'(bus.idle), 32'd1);
    chk("single_hold_addr", 32'(bus.rf_wraddr), 32'd5);

    // All three valid continuously straight after a reset.
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    bus.req_addr  = {5'd3, 5'd2, 5'd1};
    bus.req_data  = {32'hC, 32'hB, 32'hA};
    bus.req_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      #1;
      chk("rr_ready", 32'(bus.req_ready), 32'(3'b001 << (n % 3)));
      chk("rr_onehot", 32'($countones(bus.req_ready)), 32'd1);
      tick();
      chk("rr_grant", 32'(bus.grant_idx), 32'(n % 3));
      chk("rr_wren", 32'(bus.rf_wren), 32'd1);
      chk("rr_data", bus.rf_data_in, 32'(32'hA + (n % 3)));
    end
    bus.req_valid = '0;
    tick();
    chk("rr_drain", 32'(bus.rf_wren), 32'd0);

    // Req 0 and req 2 both target addr 7; rr_ptr is 0 here.
    bus.req_addr  = {5'd7, 5'd0, 5'd7};
    bus.req_data  = {32'h22, 32'h0, 32'h11};
    bus.req_valid = 3'b101;
    #1;
    chk("same_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 3'b100;
    chk("same_first_data", bus.rf_data_in, 32'h11);
    chk("same_first_addr", 32'(bus.rf_wraddr), 32'd7);
    #1;
    chk("same_ready2", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    chk("same_last_wren", 32'(bus.rf_wren), 32'd1);
    chk("same_last_addr", 32'(bus.rf_wraddr), 32'd7);
    chk("same_last_data", bus.rf_data_in, 32'h22);
    tick();

    // Hazard: req 2 waits on addr 9 behind req 0 (addr 3); rr_ptr is 0.
    bus.req_addr    = {5'd9, 5'd0, 5'd3};
    bus.req_valid   = 3'b101;
    bus.chk_addr[0] = 5'd9;
    bus.chk_addr[1] = 5'd3;
    #1;
    chk("haz_ready", 32'(bus.req_ready), 32'h1);
    chk("haz_busy_wait", 32'(bus.chk_busy), 32'b11);
    tick();
    bus.req_valid = 3'b100;
    #1;
    chk("haz_busy_pend", 32'(bus.chk_busy), 32'b11);
    tick();
    bus.req_valid = '0;
    #1;
    chk("haz_stage_wren", 32'(bus.rf_wren), 32'd1);
    chk("haz_busy_stage", 32'(bus.chk_busy), 32'b01);
    tick();
    chk("haz_busy_clear", 32'(bus.chk_busy), 32'b00);

    // Write to hardwired register 0 by req 1.
    bus.req_addr[1] = 5'd0;
    bus.req_data[1] = 32'hFFFF;
    bus.req_valid   = 3'b010;
    bus.chk_addr[0] = 5'd0;
    #1;
    chk("zero_ready", 32'(bus.req_ready), 32'h2);
    chk("zero_busy_req", 32'(bus.chk_busy[0]), 32'd0);
    tick();
    bus.req_valid = '0;
    #1;
    chk("zero_wren", 32'(bus.rf_wren), 32'd0);
    chk("zero_grant", 32'(bus.grant_idx), 32'd1);
    chk("zero_busy_stage", 32'(bus.chk_busy[0]), 32'd0);
    chk("zero_not_idle", 32'(bus.idle), 32'd0);
    tick();
    chk("zero_idle", 32'(bus.idle), 32'd1);

    // Async reset right after acceptance; rr_ptr is 2 going in.
    bus.req_addr  = {5'd0, 5'd6, 5'd4};
    bus.req_data  = {32'h0, 32'h66, 32'h44};
    bus.req_valid = 3'b011;
    #1;
    chk("ar_ready_pre", 32'(bus.req_ready), 32'h1);
    tick();
    chk("ar_wren_pre", 32'(bus.rf_wren), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("ar_wren_async", 32'(bus.rf_wren), 32'd0);
    chk("ar_ready_rst", 32'(bus.req_ready), 32'd0);
    #1;
    rstn = 1'b1;
    #1;
    chk("ar_ready_post", 32'(bus.req_ready), 32'h1);
    tick();
    chk("ar_grant_post", 32'(bus.grant_idx), 32'd0);
    chk("ar_addr_post", 32'(bus.rf_wraddr), 32'd4);
    bus.req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
